// File: rtl/dc_strobe_seq.sv
// dc_strobe_seq: programmable strobe sequencer for peripheral chip selects.
// A request with an (AW+1)-bit address starts one sequence: SETUP, then
// STROBE (stretchable by wait_in), then RECOVER. Every output comes
// straight from a flop.
//
// Ports:
//   clk_in  - clock; all state changes happen on its rising edge
//   res     - asynchronous reset, active-high
//   req     - request, sampled only while idle
//   A       - address; A[AW] is the range bit and must be 0 for a valid request
//   wait_in - stretches the strobe; sampled only in its last counted cycle
//   Q/Qn    - one-hot strobe and its bitwise complement
//   busy    - high from the accept edge until the sequence ends
//   done    - one-cycle pulse when the sequence completes
//   err     - one-cycle pulse after an out-of-range request
module dc_strobe_seq #(
  parameter int AW         = 3,
  parameter int SETUP_LEN  = 1,
  parameter int STROBE_LEN = 2,
  parameter int GAP_LEN    = 1
) (
  input  logic              clk_in,
  input  logic              res,
  input  logic              req,
  input  logic [AW:0]       A,
  input  logic              wait_in,
  output logic [2**AW-1:0]  Q,
  output logic [2**AW-1:0]  Qn,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int N      = 2**AW;
  localparam int MAXL_A = (SETUP_LEN > STROBE_LEN) ? SETUP_LEN : STROBE_LEN;
  localparam int MAXL   = (MAXL_A > GAP_LEN) ? MAXL_A : GAP_LEN;
  localparam int CW     = $clog2(MAXL) + 1;

  // Each counted state loads (length - 1) and leaves when the counter hits 0.
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] SETUP_LD  = (SETUP_LEN > 0) ? CW'(SETUP_LEN - 1) : CNT_ZERO;
  localparam logic [CW-1:0] STROBE_LD = CW'(STROBE_LEN - 1);
  localparam logic [CW-1:0] GAP_LD    = (GAP_LEN > 0) ? CW'(GAP_LEN - 1) : CNT_ZERO;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    STROBE  = 2'd2,
    RECOVER = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   a_q, a_d;
  logic [N-1:0]    q_q, q_d;
  logic [N-1:0]    qn_q, qn_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  function automatic logic [N-1:0] onehot(input logic [AW-1:0] idx);
    logic [N-1:0] v;
    v      = {N{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  // Next-state and next-output computation; outputs are decoded from the
  // next state so that the flops present them in the cycle they apply to.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    q_d     = {N{1'b0}};
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (req && A[AW]) begin
          err_d = 1'b1;
        end else if (req) begin
          a_d    = A[AW-1:0];
          busy_d = 1'b1;
          if (SETUP_LEN > 0) begin
            state_d = SETUP;
            cnt_d   = SETUP_LD;
          end else begin
            state_d = STROBE;
            cnt_d   = STROBE_LD;
            q_d     = onehot(A[AW-1:0]);
          end
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        if (cnt_q != CNT_ZERO) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          state_d = STROBE;
          cnt_d   = STROBE_LD;
          q_d     = onehot(a_q);
        end
      end
      STROBE: begin
        if (cnt_q != CNT_ZERO) begin
          cnt_d = cnt_q - CNT_ONE;
          q_d   = onehot(a_q);
        end else if (wait_in) begin
          // Stretch: hold in the last strobe cycle with no upper bound.
          q_d = onehot(a_q);
        end else if (GAP_LEN > 0) begin
          state_d = RECOVER;
          cnt_d   = GAP_LD;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      RECOVER: begin
        if (cnt_q != CNT_ZERO) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
        busy_d  = 1'b0;
      end
    endcase
    qn_d = ~q_d;
  end

  // State, counter, captured address and all output registers.
  always_ff @(posedge clk_in or posedge res) begin
    if (res) begin
      state_q <= IDLE;
      cnt_q   <= CNT_ZERO;
      a_q     <= {AW{1'b0}};
      q_q     <= {N{1'b0}};
      qn_q    <= {N{1'b1}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      q_q     <= q_d;
      qn_q    <= qn_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign Q    = q_q;
  assign Qn   = qn_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_dc_strobe_seq.sv
// Directed testbench for dc_strobe_seq with default parameters
// (AW=3, SETUP_LEN=1, STROBE_LEN=2, GAP_LEN=1). Inputs change 1 time unit
// after a rising edge; outputs are checked at the same point.
module tb_dc_strobe_seq;

  logic       clk_in;
  logic       res;
  logic       req;
  logic [3:0] A;
  logic       wait_in;
  logic [7:0] Q;
  logic [7:0] Qn;
  logic       busy;
  logic       done;
  logic       err;

  int n_cmp;
  int n_err;

  dc_strobe_seq dut (
    .clk_in (clk_in),
    .res    (res),
    .req    (req),
    .A      (A),
    .wait_in(wait_in),
    .Q      (Q),
    .Qn     (Qn),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check all outputs of one cycle at once.
  task automatic chk_all(input string tag, input logic [7:0] eq, input logic eb,
                         input logic ed, input logic ee);
    chk({tag, ".Q"}, {24'd0, Q}, {24'd0, eq});
    chk({tag, ".Qn"}, {24'd0, Qn}, {24'd0, ~eq});
    chk({tag, ".busy"}, {31'd0, busy}, {31'd0, eb});
    chk({tag, ".done"}, {31'd0, done}, {31'd0, ed});
    chk({tag, ".err"}, {31'd0, err}, {31'd0, ee});
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    res     = 1'b1;
    req     = 1'b0;
    A       = 4'h0;
    wait_in = 1'b0;

    // 1. Reset with clock running, then hold after release.
    tick(); tick();
    chk_all("rst", 8'h00, 1'b0, 1'b0, 1'b0);
    res = 1'b0;
    tick(); chk_all("rst_hold1", 8'h00, 1'b0, 1'b0, 1'b0);
    tick(); chk_all("rst_hold2", 8'h00, 1'b0, 1'b0, 1'b0);

    // 2. Basic sequence, A=5.
    req = 1'b1; A = 4'h5;                                  // cycle 0
    tick(); req = 1'b0; chk_all("b_c1", 8'h00, 1'b1, 1'b0, 1'b0);
    tick(); chk_all("b_c2", 8'h20, 1'b1, 1'b0, 1'b0);
    tick(); chk_all("b_c3", 8'h20, 1'b1, 1'b0, 1'b0);
    tick(); chk_all("b_c4", 8'h00, 1'b1, 1'b0, 1'b0);
    tick(); chk_all("b_c5", 8'h00, 1'b0, 1'b1, 1'b0);
    tick(); chk_all("b_c6", 8'h00, 1'b0, 1'b0, 1'b0);

    // 3. Out-of-range request.
    req = 1'b1; A = 4'hA;
    tick(); req = 1'b0; chk_all("oor_c1", 8'h00, 1'b0, 1'b0, 1'b1);
    tick(); chk_all("oor_c2", 8'h00, 1'b0, 1'b0, 1'b0);
    tick(); chk_all("oor_c3", 8'h00, 1'b0, 1'b0, 1'b0);

    // 4. Wait stretch: wait_in high in cycles 3-5.
    req = 1'b1; A = 4'h5;
    tick(); req = 1'b0; chk_all("w_c1", 8'h00, 1'b1, 1'b0, 1'b0);
    tick(); chk_all("w_c2", 8'h20, 1'b1, 1'b0, 1'b0);
    tick(); wait_in = 1'b1; chk_all("w_c3", 8'h20, 1'b1, 1'b0, 1'b0);
    tick(); chk_all("w_c4", 8'h20, 1'b1, 1'b0, 1'b0);
    tick(); chk_all("w_c5", 8'h20, 1'b1, 1'b0, 1'b0);
    tick(); wait_in = 1'b0; chk_all("w_c6", 8'h20, 1'b1, 1'b0, 1'b0);
    tick(); chk_all("w_c7", 8'h00, 1'b1, 1'b0, 1'b0);
    tick(); chk_all("w_c8", 8'h00, 1'b0, 1'b1, 1'b0);
    tick();

    // 4b. wait_in only in cycle 2 is ignored.
    req = 1'b1; A = 4'h5;
    tick(); req = 1'b0;
    tick(); wait_in = 1'b1; chk_all("we_c2", 8'h20, 1'b1, 1'b0, 1'b0);
    tick(); wait_in = 1'b0; chk_all("we_c3", 8'h20, 1'b1, 1'b0, 1'b0);
    tick(); chk_all("we_c4", 8'h00, 1'b1, 1'b0, 1'b0);
    tick(); chk_all("we_c5", 8'h00, 1'b0, 1'b1, 1'b0);
    tick();

    // 5. Asynchronous reset in the middle of the strobe.
    req = 1'b1; A = 4'h5;
    tick(); req = 1'b0;
    tick(); chk_all("ra_c2", 8'h20, 1'b1, 1'b0, 1'b0);
    #2 res = 1'b1;
    #1 chk_all("ra_async", 8'h00, 1'b0, 1'b0, 1'b0);
    #1 res = 1'b0;
    tick(); chk_all("ra_c3", 8'h00, 1'b0, 1'b0, 1'b0);
    tick(); chk_all("ra_c4", 8'h00, 1'b0, 1'b0, 1'b0);
    tick(); chk_all("ra_c5", 8'h00, 1'b0, 1'b0, 1'b0);
    req = 1'b1; A = 4'h3;
    tick(); req = 1'b0; chk_all("rb_c1", 8'h00, 1'b1, 1'b0, 1'b0);
    tick(); chk_all("rb_c2", 8'h08, 1'b1, 1'b0, 1'b0);
    tick(); chk_all("rb_c3", 8'h08, 1'b1, 1'b0, 1'b0);
    tick(); chk_all("rb_c4", 8'h00, 1'b1, 1'b0, 1'b0);
    tick(); chk_all("rb_c5", 8'h00, 1'b0, 1'b1, 1'b0);
    tick();

    // 6. Back-to-back with req held; A change while busy is ignored.
    req = 1'b1; A = 4'h0;
    tick(); chk_all("bb_c1", 8'h00, 1'b1, 1'b0, 1'b0);
    tick(); A = 4'h7; chk_all("bb_c2", 8'h01, 1'b1, 1'b0, 1'b0);
    tick(); chk_all("bb_c3", 8'h01, 1'b1, 1'b0, 1'b0);
    tick(); chk_all("bb_c4", 8'h00, 1'b1, 1'b0, 1'b0);
    tick(); chk_all("bb_c5", 8'h00, 1'b0, 1'b1, 1'b0);
    tick(); req = 1'b0; chk_all("bb_c6", 8'h00, 1'b1, 1'b0, 1'b0);
    tick(); chk_all("bb_c7", 8'h80, 1'b1, 1'b0, 1'b0);
    tick(); chk_all("bb_c8", 8'h80, 1'b1, 1'b0, 1'b0);
    tick(); chk_all("bb_c9", 8'h00, 1'b1, 1'b0, 1'b0);
    tick(); chk_all("bb_c10", 8'h00, 1'b0, 1'b1, 1'b0);
    tick(); chk_all("bb_c11", 8'h00, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
